// File: rtl/reaction_timer_core.sv
// reaction_timer_core: random pre-delay, then BCD millisecond reaction counter with best-time tracking,
// false-start and timeout detection.
module reaction_timer_core #(
  parameter int          CLK_FREQ_HZ  = 100000000,
  parameter int          NUM_DIGITS   = 4,
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RANGE_MASK   = 2047,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  output logic                    led,
  output logic [4*NUM_DIGITS-1:0] bcd_time,
  output logic [4*NUM_DIGITS-1:0] bcd_best,
  output logic [2:0]              state,
  output logic                    result_valid,
  output logic                    new_best
);
  localparam int TICKS = CLK_FREQ_HZ / 1000;
  localparam int PW = TICKS > 1 ? $clog2(TICKS) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + RANGE_MASK + 2);
  localparam int BW = 4 * NUM_DIGITS;
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT = 3'd1, ARMED = 3'd2, DONE = 3'd3, FALSE_START = 3'd4, TIMEOUT = 3'd5
  } state_t;
  state_t st, nxt;
  logic [2:0] start_sy, stop_sy;
  logic start_ev, stop_ev, tick, go, all9, finish, better;
  logic [15:0] lfsr;
  logic [PW-1:0] presc;
  logic [DW-1:0] delay;
  logic [BW-1:0] inc;
  assign start_ev = start_sy[1] & ~start_sy[2];
  assign stop_ev  = stop_sy[1] & ~stop_sy[2];
  assign tick     = presc == PW'(TICKS - 1);
  assign led      = st == ARMED;
  assign state    = st;
  assign finish   = st == ARMED && nxt == DONE;
  assign better   = bcd_time < bcd_best;
  always_comb begin
    inc  = bcd_time;
    all9 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc[4*i+:4] = all9 ? (bcd_time[4*i+:4] == 4'd9 ? 4'd0 : bcd_time[4*i+:4] + 4'd1) : bcd_time[4*i+:4];
      all9 = all9 & (bcd_time[4*i+:4] == 4'd9);
    end
  end
  always_comb begin
    nxt = st;
    go  = 1'b0;
    case (st)
      WAIT: begin
        if (stop_ev) nxt = FALSE_START;
        else if (tick && delay <= DW'(1)) nxt = ARMED;
      end
      ARMED: begin
        if (stop_ev) nxt = DONE;
        else if (tick && all9) nxt = TIMEOUT;
      end
      default: begin
        go = start_ev;
        if (start_ev) nxt = WAIT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  end
  // synchronisers reset high so a button held through reset release gives no press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sy     <= '1;
      stop_sy      <= '1;
      lfsr         <= LFSR_SEED;
      presc        <= '0;
      delay        <= '0;
      bcd_time     <= '0;
      bcd_best     <= {NUM_DIGITS{4'h9}};
      result_valid <= 1'b0;
      new_best     <= 1'b0;
    end else begin
      start_sy     <= {start_sy[1:0], start};
      stop_sy      <= {stop_sy[1:0], stop};
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      presc        <= (tick || (nxt != st && (nxt == WAIT || nxt == ARMED))) ? '0 : presc + 1'b1;
      delay        <= go ? DW'(MIN_DELAY_MS) + DW'({16'd0, lfsr} & RANGE_MASK)
                    : (st == WAIT && tick) ? delay - 1'b1 : delay;
      bcd_time     <= go ? '0 : (st == ARMED && nxt == ARMED && tick) ? inc : bcd_time;
      result_valid <= finish;
      new_best     <= finish && better;
      if (finish && better) bcd_best <= bcd_time;
    end
  end
endmodule

// File: tb/tb_reaction_timer_core.sv
// tb_reaction_timer_core: directed rounds checked every cycle against a millisecond-level behavioural model.
module tb_reaction_timer_core;
  localparam int ND = 3, TPM = 10, MIN = 5, MAXV = 999;
  logic clk = 0, rst_n = 0, start = 0, stop = 0;
  logic led, result_valid, new_best;
  logic [4*ND-1:0] bcd_time, bcd_best;
  logic [2:0] state;
  int total = 0, bad = 0, cyc = 0, rv_cnt = 0, nb_cnt = 0;
  int m_state, m_elapsed, m_best, m_delay, ph, nph;
  bit m_rv, m_nb, se, pe, tk;
  bit [2:0] s_hist, p_hist;

  reaction_timer_core #(.CLK_FREQ_HZ(10000), .NUM_DIGITS(ND), .MIN_DELAY_MS(MIN), .RANGE_MASK(0),
    .LFSR_SEED(16'hACE1)) dut (.clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .led(led),
    .bcd_time(bcd_time), .bcd_best(bcd_best), .state(state), .result_valid(result_valid), .new_best(new_best));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*ND-1:0] to_bcd(input int n);
    logic [4*ND-1:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i+:4] = 4'((n / (10 ** i)) % 10);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model: one state per round phase, elapsed ms as an integer, buttons seen through a 2-sample delay
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_elapsed = 0; m_best = MAXV; m_delay = 0; ph = 0;
      m_rv = 0; m_nb = 0; s_hist = 3'b111; p_hist = 3'b111;
    end else begin
      se = s_hist[1] && !s_hist[2];
      pe = p_hist[1] && !p_hist[2];
      tk = ph == TPM - 1;
      nph = tk ? 0 : ph + 1;
      m_rv = 0; m_nb = 0;
      case (m_state)
        1: if (pe) m_state = 4;
           else if (tk) begin
             m_delay--;
             if (m_delay <= 0) begin m_state = 2; nph = 0; end
           end
        2: if (pe) begin
             m_state = 3; m_rv = 1;
             if (m_elapsed < m_best) begin m_best = m_elapsed; m_nb = 1; end
           end else if (tk) begin
             if (m_elapsed == MAXV) m_state = 5;
             else m_elapsed++;
           end
        default: if (se) begin m_state = 1; m_delay = MIN; m_elapsed = 0; nph = 0; end
      endcase
      ph = nph;
      s_hist = {s_hist[1:0], start};
      p_hist = {p_hist[1:0], stop};
    end
  end

  always @(negedge clk) if (cyc > 0) begin
    chk("led", led, m_state == 2);
    chk("state", state, m_state);
    chk("bcd_time", bcd_time, to_bcd(m_elapsed));
    chk("bcd_best", bcd_best, to_bcd(m_best));
    chk("result_valid", result_valid, m_rv);
    chk("new_best", new_best, m_nb);
    rv_cnt += result_valid;
    nb_cnt += new_best;
  end

  task automatic wait_state(input logic [2:0] s, input int maxc, input string name, output int at);
    int n = 0;
    while (state !== s && n < maxc) begin @(negedge clk); n++; end
    chk(name, state, s);
    at = cyc;
  endtask

  task automatic wait_led(input logic v, input int maxc, input string name, output int at);
    int n = 0;
    while (led !== v && n < maxc) begin @(negedge clk); n++; end
    chk(name, led, v);
    at = cyc;
  endtask

  task automatic press_start(output int c0);
    start = 1;
    wait_state(3'd1, 10, "enter_wait", c0);
    start = 0;
  endtask

  task automatic play_round(input int hold, input int exp_bcd, input string name);
    int c0, c1, c2;
    press_start(c0);
    wait_led(1'b1, 100, {name, "_led_rise"}, c1);
    chk({name, "_led_delay"}, c1 - c0, 50);
    repeat (hold) @(negedge clk);
    stop = 1;
    wait_state(3'd3, 10, {name, "_done"}, c2);
    chk({name, "_result"}, bcd_time, exp_bcd);
    stop = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_led", led, 0);
    chk("rst_time", bcd_time, 'h000);
    chk("rst_best", bcd_best, 'h999);
    rst_n = 1;
    repeat (5) @(negedge clk);
    play_round(370, 'h037, "r1");
    chk("r1_best", bcd_best, 'h037);
    chk("r1_rv_cnt", rv_cnt, 1);
    chk("r1_nb_cnt", nb_cnt, 1);
    play_round(520, 'h052, "r2");
    chk("r2_best", bcd_best, 'h037);
    chk("r2_rv_cnt", rv_cnt, 2);
    chk("r2_nb_cnt", nb_cnt, 1);
    play_round(370, 'h037, "r3");
    chk("r3_rv_cnt", rv_cnt, 3);
    chk("r3_nb_cnt", nb_cnt, 1);
    press_start(c0);
    repeat (20) @(negedge clk);
    stop = 1;
    wait_state(3'd4, 10, "false_start", c1);
    chk("fs_time", bcd_time, 'h000);
    chk("fs_led", led, 0);
    stop = 0;
    repeat (100) @(negedge clk);
    chk("fs_hold", state, 4);
    chk("fs_rv_cnt", rv_cnt, 3);
    press_start(c0);
    wait_led(1'b1, 100, "rst_round_led", c1);
    repeat (150) @(negedge clk);
    start = 1;
    repeat (20) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_led", led, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_time", bcd_time, 'h000);
    chk("async_rst_best", bcd_best, 'h999);
    @(negedge clk);
    rst_n = 1;
    repeat (50) @(negedge clk);
    chk("held_start_no_event", state, 0);
    start = 0;
    repeat (5) @(negedge clk);
    play_round(97, 'h009, "tie");
    chk("tie_best", bcd_best, 'h009);
    chk("tie_rv_cnt", rv_cnt, 4);
    chk("tie_nb_cnt", nb_cnt, 2);
    press_start(c0);
    wait_led(1'b1, 100, "to_led_rise", c1);
    wait_state(3'd5, 10100, "timeout", c2);
    chk("to_led_len", c2 - c1, 10000);
    chk("to_time", bcd_time, 'h999);
    chk("to_led", led, 0);
    repeat (3) @(negedge clk);
    chk("to_rv_cnt", rv_cnt, 4);
    press_start(c0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
